// File: rtl/elastic_pipe_reg_pkg.sv
// Shared CPU stage types carried through elastic_pipe_reg as opaque payloads.
// The halt flag sits in the MSB of each stage struct so HALT_BIT = $bits(<stage>_t)-1.
package elastic_pipe_reg_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_SLT = 4'd7
    } aluop_t;

    typedef struct packed {
        logic       halt;
        aluop_t     aluOp;
        word_t      aluResult;
        word_t      storeData;
        logic [4:0] rd;
        logic       memRead;
        logic       memWrite;
        logic       regWrite;
    } ex_mem_t;

    typedef struct packed {
        logic       halt;
        word_t      wbData;
        logic [4:0] rd;
        logic       regWrite;
    } mem_wb_t;

    localparam int unsigned WORD_W = $bits(word_t);

endpackage

// File: rtl/elastic_pipe_reg.sv
// N-deep elastic inter-stage register with valid/ready handshake, flush and
// sticky halt capture; storage is a circular buffer with explicit pointer wrap.
module elastic_pipe_reg
    import elastic_pipe_reg_pkg::*;
#(
    parameter int unsigned DW       = WORD_W,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned HALT_BIT = 0,
    localparam int unsigned CW      = $clog2(DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [CW-1:0] occupancy,
    output logic          halted
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem_r [DEPTH];
    logic [PW-1:0] rdPtr_r;
    logic [PW-1:0] wrPtr_r;
    logic [CW-1:0] count_r;
    logic          halted_r;

    logic          notEmpty_s;
    logic          pop_s;
    logic          push_s;
    logic          inReady_s;

    // DEPTH need not be a power of two, so wrap is an explicit compare
    function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] ptr);
        logic [PW-1:0] nxt;
        if (ptr == PW'(DEPTH - 1)) begin
            nxt = {PW{1'b0}};
        end else begin
            nxt = ptr + PW'(1);
        end
        return nxt;
    endfunction

    // Output view of the oldest entry and the pop handshake
    always_comb begin
        notEmpty_s = (count_r != {CW{1'b0}});
        out_valid  = notEmpty_s & ~halted_r;
        pop_s      = out_valid & out_ready;
        if (notEmpty_s) begin
            out_data = mem_r[rdPtr_r];
        end else begin
            out_data = {DW{1'b0}};
        end
    end

    generate
        if (DEPTH == 1) begin : gReadySingle
            // A single slot can only stream back-to-back by looking at out_ready
            always_comb begin
                inReady_s = (~notEmpty_s | pop_s) & ~halted_r;
            end
        end else begin : gReadyMulti
            // Deeper buffers keep in_ready free of any path from out_ready
            always_comb begin
                inReady_s = (count_r < CW'(DEPTH)) & ~halted_r;
            end
        end
    endgenerate

    assign push_s    = in_valid & inReady_s & ~flush;
    assign in_ready  = inReady_s;
    assign occupancy = count_r;
    assign halted    = halted_r;

    // Storage, pointers, occupancy and halt capture; halted freezes everything
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= {DW{1'b0}};
            end
            rdPtr_r  <= {PW{1'b0}};
            wrPtr_r  <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            halted_r <= 1'b0;
        end else if (!halted_r) begin
            // a pop coinciding with flush is still consumed, so halt capture comes first
            if (pop_s && out_data[HALT_BIT]) begin
                halted_r <= 1'b1;
            end
            if (flush) begin
                rdPtr_r <= {PW{1'b0}};
                wrPtr_r <= {PW{1'b0}};
                count_r <= {CW{1'b0}};
            end else begin
                if (push_s) begin
                    mem_r[wrPtr_r] <= in_data;
                    wrPtr_r        <= ptrInc(wrPtr_r);
                end
                if (pop_s) begin
                    rdPtr_r <= ptrInc(rdPtr_r);
                end
                case ({push_s, pop_s})
                    2'b10:   count_r <= count_r + CW'(1);
                    2'b01:   count_r <= count_r - CW'(1);
                    default: count_r <= count_r;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Directed bench for elastic_pipe_reg: DEPTH=2 ordering and halt, DEPTH=3
// wrap/flush, DEPTH=1 streaming replacement, async reset.
module tb_elastic_pipe_reg;

    logic CLK;
    logic nRST;

    logic        flush2, inValid2, inReady2, outValid2, outReady2, halted2;
    logic [31:0] inData2, outData2;
    logic [1:0]  occ2;

    logic        flush3, inValid3, inReady3, outValid3, outReady3, halted3;
    logic [31:0] inData3, outData3;
    logic [1:0]  occ3;

    logic        flush1, inValid1, inReady1, outValid1, outReady1, halted1;
    logic [31:0] inData1, outData1;
    logic [0:0]  occ1;

    int vectors;
    int errors;

    elastic_pipe_reg #(.DW(32), .DEPTH(2), .HALT_BIT(31)) u2 (
        .CLK(CLK), .nRST(nRST), .flush(flush2),
        .in_valid(inValid2), .in_ready(inReady2), .in_data(inData2),
        .out_valid(outValid2), .out_ready(outReady2), .out_data(outData2),
        .occupancy(occ2), .halted(halted2)
    );

    elastic_pipe_reg #(.DW(32), .DEPTH(3), .HALT_BIT(31)) u3 (
        .CLK(CLK), .nRST(nRST), .flush(flush3),
        .in_valid(inValid3), .in_ready(inReady3), .in_data(inData3),
        .out_valid(outValid3), .out_ready(outReady3), .out_data(outData3),
        .occupancy(occ3), .halted(halted3)
    );

    elastic_pipe_reg #(.DW(32), .DEPTH(1), .HALT_BIT(31)) u1 (
        .CLK(CLK), .nRST(nRST), .flush(flush1),
        .in_valid(inValid1), .in_ready(inReady1), .in_data(inData1),
        .out_valid(outValid1), .out_ready(outReady1), .out_data(outData1),
        .occupancy(occ1), .halted(halted1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin : stim
        int          mCount;
        int          popped;
        int          pushed;
        logic [31:0] q[$];
        logic        mPush;
        logic        mPop;

        vectors = 0;
        errors  = 0;
        nRST = 1'b0;
        {flush2, inValid2, outReady2} = 3'b000; inData2 = 32'h0;
        {flush3, inValid3, outReady3} = 3'b000; inData3 = 32'h0;
        {flush1, inValid1, outReady1} = 3'b000; inData1 = 32'h0;

        // 1 reset state
        #3;
        chk("rst_out_valid", {31'd0, outValid2}, 32'd0);
        chk("rst_out_data", outData2, 32'd0);
        chk("rst_occupancy", {30'd0, occ2}, 32'd0);
        chk("rst_in_ready", {31'd0, inReady2}, 32'd1);
        chk("rst_halted", {31'd0, halted2}, 32'd0);
        chk("rst_in_ready_d1", {31'd0, inReady1}, 32'd1);
        tick();
        nRST = 1'b1;
        tick();

        // 2 DEPTH=2 fill with back-pressure, then drain in order
        inValid2 = 1'b1; inData2 = 32'h0000_00A1;
        tick();
        chk("d2_lat1_valid", {31'd0, outValid2}, 32'd1);
        chk("d2_lat1_data", outData2, 32'h0000_00A1);
        inData2 = 32'h0000_00B2;
        tick();
        chk("d2_full_occ", {30'd0, occ2}, 32'd2);
        chk("d2_full_in_ready", {31'd0, inReady2}, 32'd0);
        inValid2 = 1'b0; outReady2 = 1'b1;
        #1;
        chk("d2_pop0", outData2, 32'h0000_00A1);
        tick();
        chk("d2_pop1", outData2, 32'h0000_00B2);
        chk("d2_occ1", {30'd0, occ2}, 32'd1);
        tick();
        chk("d2_empty_valid", {31'd0, outValid2}, 32'd0);
        chk("d2_empty_data", outData2, 32'd0);
        outReady2 = 1'b0;

        // 3 DEPTH=3 stream of 10 words with toggling out_ready, wrapping pointers
        mCount = 0; popped = 0; pushed = 0;
        for (int cyc = 0; cyc < 60 && popped < 10; cyc++) begin
            inValid3  = (pushed < 10);
            inData3   = 32'h0000_0030 + 32'(pushed);
            outReady3 = (((cyc >> 2) & 1) == 1);
            #1;
            chk("d3_in_ready", {31'd0, inReady3}, {31'd0, (mCount < 3)});
            if (mCount != 0) chk("d3_out_data", outData3, q[0]);
            chk("d3_out_valid", {31'd0, outValid3}, {31'd0, (mCount != 0)});
            mPush = inValid3 && (mCount < 3);
            mPop  = (mCount != 0) && outReady3;
            tick();
            if (mPop) begin
                void'(q.pop_front());
                popped++;
            end
            if (mPush) begin
                q.push_back(32'h0000_0030 + 32'(pushed));
                pushed++;
            end
            mCount = q.size();
            chk("d3_occupancy", {30'd0, occ3}, 32'(mCount));
        end
        chk("d3_all_popped", 32'(popped), 32'd10);
        inValid3 = 1'b0; outReady3 = 1'b0;

        // 4 flush with two held and a push in flight on DEPTH=3
        inValid3 = 1'b1; inData3 = 32'h0000_0011;
        tick();
        inData3 = 32'h0000_0022;
        tick();
        chk("fl_held", {30'd0, occ3}, 32'd2);
        inData3 = 32'h0000_00C3; flush3 = 1'b1;
        tick();
        flush3 = 1'b0; inValid3 = 1'b0;
        chk("fl_occ", {30'd0, occ3}, 32'd0);
        chk("fl_valid", {31'd0, outValid3}, 32'd0);
        outReady3 = 1'b1;
        tick();
        chk("fl_no_c3", outData3, 32'd0);
        chk("fl_still_empty", {30'd0, occ3}, 32'd0);
        outReady3 = 1'b0;

        // 6 DEPTH=1 full, pop and push together replace the word in one cycle
        inValid1 = 1'b1; inData1 = 32'h0000_0061;
        tick();
        chk("d1_full_occ", {31'd0, occ1}, 32'd1);
        chk("d1_full_ready", {31'd0, inReady1}, 32'd0);
        outReady1 = 1'b1; inData1 = 32'h0000_0062;
        #1;
        chk("d1_pass_ready", {31'd0, inReady1}, 32'd1);
        tick();
        chk("d1_replace_data", outData1, 32'h0000_0062);
        chk("d1_replace_occ", {31'd0, occ1}, 32'd1);
        inValid1 = 1'b0;
        tick();
        chk("d1_drained", {31'd0, outValid1}, 32'd0);
        outReady1 = 1'b0;

        // 5 halt capture on DEPTH=2, frozen state, flush-proof, async reset clears
        inValid2 = 1'b1; inData2 = 32'h8000_0000;
        tick();
        inData2 = 32'h0000_0077;
        tick();
        inValid2 = 1'b0;
        chk("h_before", {31'd0, halted2}, 32'd0);
        outReady2 = 1'b1;
        tick();
        chk("h_halted", {31'd0, halted2}, 32'd1);
        chk("h_in_ready", {31'd0, inReady2}, 32'd0);
        chk("h_out_valid", {31'd0, outValid2}, 32'd0);
        chk("h_occ", {30'd0, occ2}, 32'd1);
        inValid2 = 1'b1; inData2 = 32'h0000_0055;
        tick();
        chk("h_frozen_occ", {30'd0, occ2}, 32'd1);
        inValid2 = 1'b0; flush2 = 1'b1;
        tick();
        flush2 = 1'b0;
        chk("h_flush_keeps", {31'd0, halted2}, 32'd1);
        chk("h_flush_frozen", {30'd0, occ2}, 32'd1);
        #2;
        nRST = 1'b0;
        #1;
        chk("h_rst_halted", {31'd0, halted2}, 32'd0);
        chk("h_rst_occ", {30'd0, occ2}, 32'd0);
        chk("h_rst_data", outData2, 32'd0);
        chk("h_rst_in_ready", {31'd0, inReady2}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
